// File: rtl/iru_rot_coord_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : iru_rot_coord_gen_if
// Purpose : Valid/ready coordinate stream from the rotation coordinate
//           generator to the pixel-fetch stage.
// Revision: 1.0
// ============================================================================
interface iru_rot_coord_gen_if #(
  parameter int COORD_W = 5
);
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] dst_x;
  logic [COORD_W-1:0] dst_y;
  logic [6:0]         src_x;
  logic [6:0]         src_y;
  logic               in_bounds;
  logic               last;

  modport master (
    output out_valid, dst_x, dst_y, src_x, src_y, in_bounds, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, dst_x, dst_y, src_x, src_y, in_bounds, last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/iru_rot_coord_gen.sv
`default_nettype none
// ============================================================================
// Module  : iru_rot_coord_gen (with helper iru_sin_lut)
// Purpose : Sweeps an IMG_DIM x IMG_DIM window and emits the rotated source
//           coordinate of every destination pixel. Revision: 1.0
// ============================================================================

// One-hot angle (MSB = 0deg, 10deg steps) to sign-magnitude sine, 128 = 1.0.
module iru_sin_lut (
  input  logic [35:0] d,
  output logic [8:0]  q
);
  function automatic logic [7:0] mag_of(input int k);
    int m;
    m = (k > 9) ? 18 - k : k;
    case (m)
      0:       mag_of = 8'd0;
      1:       mag_of = 8'd22;
      2:       mag_of = 8'd44;
      3:       mag_of = 8'd64;
      4:       mag_of = 8'd82;
      5:       mag_of = 8'd98;
      6:       mag_of = 8'd111;
      7:       mag_of = 8'd120;
      8:       mag_of = 8'd126;
      9:       mag_of = 8'd128;
      default: mag_of = 8'd0;
    endcase
  endfunction

  always_comb begin
    q = '0;
    for (int b = 0; b < 36; b++) begin
      if (d[b]) begin
        q = {((35 - b) > 18), mag_of((35 - b) % 18)};
      end
    end
  end
endmodule

module iru_rot_coord_gen #(
  parameter int IMG_DIM = 20,
  parameter int COORD_W = $clog2(IMG_DIM),
  parameter int CENTER  = IMG_DIM / 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [35:0] angle,
  output logic        busy,
  output logic        done,
  output logic        err,
  iru_rot_coord_gen_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [COORD_W-1:0] c_last_coord = COORD_W'(IMG_DIM - 1);
  localparam logic signed [5:0]  c_center6    = 6'(CENTER);
  localparam logic [6:0]         c_center7    = 7'(CENTER);
  localparam logic [6:0]         c_dim7       = 7'(IMG_DIM);

  state_t state_q, state_d;

  logic [35:0]        angle_q;
  logic signed [8:0]  sin_q, cos_q;
  logic [COORD_W-1:0] x_q, y_q;

  logic               s1_valid_q, s1_last_q;
  logic [COORD_W-1:0] s1_x_q, s1_y_q;
  logic signed [12:0] m_xcos_q, m_ysin_q, m_xsin_q, m_ycos_q;

  logic               out_valid_q, in_bounds_q, last_q;
  logic [COORD_W-1:0] dst_x_q, dst_y_q;
  logic [6:0]         src_x_q, src_y_q;
  logic               done_q, err_q;

  logic [8:0]         w_sin_sm, w_cos_sm;
  logic               w_angle_ok, w_stall, w_issue, w_pix_last, w_accept_last;
  logic               w_start_ok, w_start_bad;
  logic signed [5:0]  w_xc, w_yc;
  logic signed [12:0] w_px, w_py;
  logic [6:0]         w_src_x, w_src_y;
  logic               w_inb;

  iru_sin_lut u_sin (.d(angle_q),                         .q(w_sin_sm));
  iru_sin_lut u_cos (.d({angle_q[8:0], angle_q[35:9]}),   .q(w_cos_sm));

  function automatic logic signed [8:0] sm_to_tc(input logic [8:0] sm);
    logic signed [8:0] mag;
    mag = $signed({1'b0, sm[7:0]});
    return sm[8] ? -mag : mag;
  endfunction

  assign w_angle_ok    = (angle != '0) && ((angle & (angle - 36'd1)) == '0);
  assign w_stall       = out_valid_q && !bus.out_ready;
  assign w_issue       = (state_q == RUN) && !w_stall;
  assign w_pix_last    = (x_q == c_last_coord) && (y_q == c_last_coord);
  assign w_accept_last = out_valid_q && bus.out_ready && last_q;

  always_comb begin
    state_d     = state_q;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (w_angle_ok) begin
            w_start_ok = 1'b1;
            state_d    = LOAD;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      LOAD:    state_d = RUN;
      RUN:     if (w_issue && w_pix_last) state_d = DRAIN;
      DRAIN:   if (w_accept_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: centre the destination coordinate and form the four products.
  assign w_xc = $signed(6'(x_q)) - c_center6;
  assign w_yc = $signed(6'(y_q)) - c_center6;

  // Stage 2: rotate, round half up, recentre; truncation to 7 bits is intended.
  assign w_px    = m_xcos_q + m_ysin_q;
  assign w_py    = m_ycos_q - m_xsin_q;
  assign w_src_x = 7'((w_px + 13'sd64) >>> 7) + c_center7;
  assign w_src_y = 7'((w_py + 13'sd64) >>> 7) + c_center7;
  assign w_inb   = !w_src_x[6] && (w_src_x < c_dim7) &&
                   !w_src_y[6] && (w_src_y < c_dim7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      angle_q     <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      m_xcos_q    <= '0;
      m_ysin_q    <= '0;
      m_xsin_q    <= '0;
      m_ycos_q    <= '0;
      out_valid_q <= 1'b0;
      in_bounds_q <= 1'b0;
      last_q      <= 1'b0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= w_start_bad;
      done_q  <= (state_q == DRAIN) && w_accept_last;

      if (w_start_ok) begin
        angle_q <= angle;
        x_q     <= '0;
        y_q     <= '0;
      end

      if (state_q == LOAD) begin
        sin_q <= sm_to_tc(w_sin_sm);
        cos_q <= sm_to_tc(w_cos_sm);
      end

      if (w_issue) begin
        if (x_q == c_last_coord) begin
          x_q <= '0;
          y_q <= y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end

      // The whole pipeline freezes while the output beat is refused.
      if (!w_stall) begin
        s1_valid_q <= w_issue;
        if (w_issue) begin
          s1_x_q    <= x_q;
          s1_y_q    <= y_q;
          s1_last_q <= w_pix_last;
          m_xcos_q  <= 13'(w_xc) * 13'(cos_q);
          m_ysin_q  <= 13'(w_yc) * 13'(sin_q);
          m_xsin_q  <= 13'(w_xc) * 13'(sin_q);
          m_ycos_q  <= 13'(w_yc) * 13'(cos_q);
        end
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          dst_x_q     <= s1_x_q;
          dst_y_q     <= s1_y_q;
          src_x_q     <= w_src_x;
          src_y_q     <= w_src_y;
          in_bounds_q <= w_inb;
          last_q      <= s1_last_q;
        end
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dst_x     = dst_x_q;
  assign bus.dst_y     = dst_y_q;
  assign bus.src_x     = src_x_q;
  assign bus.src_y     = src_y_q;
  assign bus.in_bounds = in_bounds_q;
  assign bus.last      = last_q;
endmodule
`default_nettype wire
